// File: rtl/switch_key_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_key_reader_pkg : register map and CTRL field layout for the reader
// Rev 1.0
// ---------------------------------------------------------------------------
package switch_key_reader_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0020;

  localparam logic [3:0] SW_OFS   = 4'h0;
  localparam logic [3:0] KEY_OFS  = 4'h4;
  localparam logic [3:0] PEND_OFS = 4'h8;
  localparam logic [3:0] CTRL_OFS = 4'hC;

  localparam int CTRL_IRQ_EN_BIT   = 0;
  localparam int CTRL_KEY_MASK_LSB = 1;

  // Byte offset of a word-aligned access relative to the block base.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr & ~32'h3) - base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_key_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_key_reader_if : CPU-side bus of the switch/key reader
// Rev 1.0
// ---------------------------------------------------------------------------
interface switch_key_reader_if;

  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, rd, wr, wdata, input rdata, irq);
  modport slave  (input addr, rd, wr, wdata, output rdata, irq);

endinterface
`default_nettype wire

// File: rtl/switch_key_reader_debounce_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_cell : 2-flop synchroniser followed by a stable-count debouncer
// Rev 1.0
// ---------------------------------------------------------------------------
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  din_async,
  output logic dout,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din_async;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_max) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
  // Combinational so the consumer can latch the event on the same edge.
  assign rise = stable_d & ~stable_q;

endmodule
`default_nettype wire

// File: rtl/switch_key_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_key_reader : debounced switch/key levels, sticky key-press pending
//                     bits and a maskable level interrupt on the CPU bus
// Rev 1.0
// ---------------------------------------------------------------------------
module switch_key_reader
  import switch_key_reader_pkg::*;
#(
  parameter int          N_SW            = 8,
  parameter int          N_KEY           = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR
) (
  input  wire              clk,
  input  wire              reset,
  input  wire [N_SW-1:0]   sw_in,
  input  wire [N_KEY-1:0]  key_in,
  switch_key_reader_if.slave bus
);

  logic [N_SW-1:0]  sw_stable, sw_rise;
  logic [N_KEY-1:0] key_stable, key_rise;

  generate
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_cell (
        .clk(clk), .reset(reset), .din_async(sw_in[i]),
        .dout(sw_stable[i]), .rise(sw_rise[i])
      );
    end
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_cell (
        .clk(clk), .reset(reset), .din_async(key_in[i]),
        .dout(key_stable[i]), .rise(key_rise[i])
      );
    end
  endgenerate

  logic [31:0] ofs;
  logic        hit;

  assign ofs = word_offset(bus.addr, BASE_ADDR);
  assign hit = (ofs < 32'd16);

  logic [N_KEY-1:0] pending_q, pending_d;
  logic [N_KEY-1:0] key_mask_q, key_mask_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  always_comb begin
    pending_d  = pending_q;
    key_mask_d = key_mask_q;
    irq_en_d   = irq_en_q;
    if (bus.wr && hit) begin
      case (ofs[3:0])
        PEND_OFS: pending_d = pending_q & ~bus.wdata[N_KEY-1:0];
        CTRL_OFS: begin
          irq_en_d   = bus.wdata[CTRL_IRQ_EN_BIT];
          key_mask_d = bus.wdata[CTRL_KEY_MASK_LSB +: N_KEY];
        end
        default: ;
      endcase
    end
    // A press arriving with a clear of the same bit must not be lost.
    pending_d = pending_d | key_rise;
    irq_d     = irq_en_d & (|(pending_d & key_mask_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      key_mask_q <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      key_mask_q <= key_mask_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd && hit) begin
      case (ofs[3:0])
        SW_OFS:   bus.rdata = 32'(sw_stable);
        KEY_OFS:  bus.rdata = 32'(key_stable);
        PEND_OFS: bus.rdata = 32'(pending_q);
        CTRL_OFS: bus.rdata = 32'({key_mask_q, irq_en_q});
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign bus.irq = irq_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, sw_rise, bus.wdata};

endmodule
`default_nettype wire

// File: tb/tb_switch_key_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_switch_key_reader : directed and random stimulus against a run-length
//                        reference model of the switch/key reader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_switch_key_reader;
  import switch_key_reader_pkg::*;

  localparam int N_SW  = 8;
  localparam int N_KEY = 4;
  localparam int N_IN  = N_SW + N_KEY;
  localparam int DC    = 4;
  localparam logic [31:0] BASE = DEFAULT_BASE_ADDR;

  logic             clk;
  logic             reset;
  logic [N_SW-1:0]  sw_in;
  logic [N_KEY-1:0] key_in;
  int               n_checks = 0;
  int               n_pass   = 0;

  switch_key_reader_if bus();

  switch_key_reader #(
    .N_SW(N_SW), .N_KEY(N_KEY), .DEBOUNCE_CYCLES(DC), .CNT_W(3), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .key_in(key_in), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each input is seen two edges late, and its accepted
  // level flips once the seen value has disagreed for DC consecutive edges.
  bit               m_s1[N_IN];
  bit               m_s2[N_IN];
  bit               m_st[N_IN];
  int               m_run[N_IN];
  logic [N_KEY-1:0] m_pend, m_mask;
  logic             m_en, m_irq;
  string            names[4] = '{"SW", "KEY", "PEND", "CTRL"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_IN; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0;
    end
    m_pend = '0; m_mask = '0; m_en = 1'b0; m_irq = 1'b0;
  endtask

  function automatic bit raw_bit(input int i);
    if (i < N_SW) return sw_in[i];
    return key_in[i-N_SW];
  endfunction

  task automatic model_edge();
    logic [N_KEY-1:0] rise;
    logic [31:0]      off;
    rise = '0;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (m_s2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_st[i]  = m_s2[i];
          m_run[i] = 0;
          if (i >= N_SW && m_st[i]) rise[i-N_SW] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw_bit(i);
    end
    if (bus.wr) begin
      off = (bus.addr & ~32'h3) - BASE;
      if (off == 32'h8) m_pend = m_pend & ~bus.wdata[N_KEY-1:0];
      else if (off == 32'hC) begin
        m_en   = bus.wdata[0];
        m_mask = bus.wdata[N_KEY:1];
      end
    end
    m_pend = m_pend | rise;
    m_irq  = m_en && ((m_pend & m_mask) != '0);
  endtask

  function automatic logic [31:0] exp_reg(input int r);
    logic [31:0] v;
    v = '0;
    case (r)
      0:       for (int i = 0; i < N_SW; i++) v[i] = m_st[i];
      1:       for (int i = 0; i < N_KEY; i++) v[i] = m_st[N_SW+i];
      2:       v[N_KEY-1:0] = m_pend;
      default: v[N_KEY:0] = {m_mask, m_en};
    endcase
    return v;
  endfunction

  task automatic check_regs();
    bus.wr = 1'b0;
    chk("irq", {31'b0, bus.irq}, {31'b0, m_irq});
    for (int r = 0; r < 4; r++) begin
      bus.addr = BASE + 32'(4*r) + 32'($urandom_range(0, 3));
      bus.rd   = 1'b1;
      #1;
      chk(names[r], bus.rdata, exp_reg(r));
    end
    bus.rd = 1'b0;
    #1;
    chk("rd_low", bus.rdata, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic bus_write(input logic [31:0] ofs, input logic [31:0] data);
    bus.addr  = BASE + ofs;
    bus.wdata = data;
    bus.wr    = 1'b1;
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] ofs, input logic [31:0] expv);
    bus.addr = BASE + ofs;
    bus.rd   = 1'b1;
    #1;
    chk(tag, bus.rdata, expv);
    bus.rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sw_in = '0; key_in = '0;
    bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wdata = '0;
    model_clear();

    // Inputs and writes toggling while held in reset.
    for (int k = 0; k < 4; k++) begin
      sw_in = N_SW'($urandom); key_in = N_KEY'($urandom);
      bus_write(32'hC, 32'h1F);
      step();
    end
    expect_rd("rst_sw", 32'h0, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    sw_in = '0; key_in = '0;
    step();
    reset = 1'b1;
    repeat (3) step();
    expect_rd("post_rst_key", 32'h4, 32'h0);

    // Switch level appears on edge 2+DC, not before.
    sw_in = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) expect_rd("sw_edge5", 32'h0, 32'h0);
      if (k == 6) expect_rd("sw_edge6", 32'h0, 32'hA5);
    end
    repeat (4) step();

    // Short key pulse is rejected.
    key_in = 4'b0100;
    repeat (3) step();
    key_in = '0;
    repeat (8) step();
    expect_rd("glitch_key", 32'h4, 32'h0);
    expect_rd("glitch_pend", 32'h8, 32'h0);

    // Enabled press raises irq on the debounce edge and stays sticky.
    bus_write(32'hC, 32'h9);
    step();
    key_in = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) chk("irq_edge5", {31'b0, bus.irq}, 32'h0);
      if (k == 6) begin
        chk("irq_edge6", {31'b0, bus.irq}, 32'h1);
        expect_rd("pend_edge6", 32'h8, 32'h4);
      end
    end
    key_in = '0;
    repeat (8) step();
    expect_rd("pend_sticky", 32'h8, 32'h4);
    chk("irq_sticky", {31'b0, bus.irq}, 32'h1);

    // Write-1-to-clear, then clear colliding with a new press.
    bus_write(32'h8, 32'h4);
    step();
    expect_rd("pend_w1c", 32'h8, 32'h0);
    chk("irq_w1c", {31'b0, bus.irq}, 32'h0);
    key_in = 4'b0100;
    repeat (5) step();
    bus_write(32'h8, 32'h4);
    step();
    expect_rd("pend_set_wins", 32'h8, 32'h4);
    chk("irq_set_wins", {31'b0, bus.irq}, 32'h1);

    // Writes to read-only and unmapped locations change nothing.
    bus_write(32'h0, 32'hFFFF_FFFF);
    step();
    bus_write(32'h10, 32'hFFFF_FFFF);
    step();
    expect_rd("ro_sw", 32'h0, 32'hA5);
    expect_rd("ro_ctrl", 32'hC, 32'h9);
    step();
    expect_rd("unmap_hi", 32'h10, 32'h0);
    expect_rd("unmap_lo", 32'hFFFF_FFFC, 32'h0);

    // Random traffic with a mid-run reset.
    for (int c = 0; c < 600; c++) begin
      int idx;
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, N_SW-1));
        sw_in[idx] = ~sw_in[idx];
      end
      if ($urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, N_KEY-1));
        key_in[idx] = ~key_in[idx];
      end
      if ($urandom_range(0, 5) == 0) bus_write(32'($urandom_range(0, 23)), $urandom);
      if (c == 300) begin
        reset = 1'b0;
        model_clear();
      end
      if (c == 302) reset = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_key_reader.md
# switch_key_reader

Memory-mapped input peripheral: the CPU-facing reader for board switches and push-buttons, the counterpart to the seven-segment/LED output path. Synchronises and debounces 8 slide switches and 4 keys, latches key-press events into sticky pending bits, and exposes levels, pending bits and an interrupt enable on the CPU data bus. Sits beside the other peripherals in the peripheral address window; `irq` feeds the CPU interrupt input.

## Interface
- `N_SW`, 8, number of slide switches
- `N_KEY`, 4, number of push-buttons (active-high when pressed)
- `DEBOUNCE_CYCLES`, 50000, consecutive stable `clk` cycles before a level is accepted (≥2)
- `CNT_W`, 16, debounce counter width; must hold `DEBOUNCE_CYCLES-1`
- `BASE_ADDR`, 32'h4000_0020, base of the 4-word register block

- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `sw_in`  in  N_SW  raw switch pins, asynchronous
- `key_in`  in  N_KEY  raw key pins, asynchronous
- `addr`  in  32  CPU byte address
- `rd`  in  1  CPU read strobe
- `wr`  in  1  CPU write strobe (one cycle per write)
- `wdata`  in  32  CPU write data
- `rdata`  out  32  read data
- `irq`  out  1  interrupt request, level

## Operation
- Every raw input: 2-flop synchroniser, then one debounce cell.
- Debounce cell: `stable` register and `cnt`. If synced == `stable`: `cnt` ← 0. Else if `cnt` == `DEBOUNCE_CYCLES-1`: `stable` ← synced, `cnt` ← 0. Else `cnt` ← `cnt`+1. Any glitch shorter than `DEBOUNCE_CYCLES` cycles leaves `stable` unchanged.
- Key press event: key `stable` transitions 0→1; sets `pending[i]` on that same edge. Release sets nothing.
- Registers (word offsets from `BASE_ADDR`):
  - +0x0 SW: RO, `{0, sw_stable}`
  - +0x4 KEY: RO, `{0, key_stable}`
  - +0x8 PEND: read `{0, pending}`; write-1-to-clear `pending & ~wdata[N_KEY-1:0]`
  - +0xC CTRL: RW, bit0 `irq_en`, bits[N_KEY+0:1] `key_mask`; other bits read 0
- Writes to RO or unmapped addresses: ignored. Address bits [1:0] ignored.
- `rdata` combinational: selected register when `rd`=1 and address mapped, else 0.
- `irq` = `irq_en` & |(`pending` & `key_mask`), driven from registers only (glitch-free).
- Simultaneous set and W1C of the same pending bit: set wins (bit stays 1).
- Reset mid-debounce: counters, stable, synchronisers all cleared; event in progress discarded.

## Timing
- Reset values: all synchroniser flops 0, `stable` 0, `cnt` 0, `pending` 0, CTRL 0, `irq` 0, `rdata` 0.
- Input change visible in sync stage 2 after 2 edges; `stable` updates on edge 2+`DEBOUNCE_CYCLES` after the change, given the input holds.
- `pending` sets on the same edge as `stable`; `irq` asserts on that edge if enabled.
- W1C / CTRL write take effect on the edge where `wr`=1; `irq` deasserts on that edge when the last enabled pending bit clears.
- Read has zero latency: `rdata` valid in the same cycle as `rd`, reflecting register state before the edge.

## Structure
- Shared package/header: register offsets (`SW_OFS`, `KEY_OFS`, `PEND_OFS`, `CTRL_OFS`), CTRL bit positions, default `BASE_ADDR`.
- Sub-module `debounce_cell` (params `DEBOUNCE_CYCLES`, `CNT_W`; ports `clk`, `reset`, `din_async`, `dout`, `rise`): includes synchroniser; instantiated N_SW+N_KEY times via generate.
- Top holds pending, CTRL, address decode, read mux, irq.

## Test plan (DEBOUNCE_CYCLES=4)
- Reset asserted low with inputs toggling → all reads return 0, `irq`=0; release reset, inputs 0 → still 0.
- `sw_in`=8'hA5 held 10 cycles → SW read = 32'h0000_00A5 on edge 6 after change, not earlier.
- `key_in[2]` pulses high 3 cycles, then 0 → KEY and PEND stay 0 (glitch rejected).
- CTRL=32'h0000_0009 (irq_en, mask bit2), `key_in[2]` held high → PEND=4, `irq`=1 on edge 6; release key → PEND still 4, `irq` still 1.
- Write PEND=32'h4 → PEND=0, `irq`=0 next cycle; write PEND=4 on the same edge a new key2 press debounces → PEND stays 4.
- Write to SW offset and to `BASE_ADDR`+0x10 → no register changes; read of unmapped address and any read with `rd`=0 → `rdata`=0.
